data_memory_responder: RTL and testbench

- Memory-side responder for the core's MEM-stage data port.
- Accepts one load/store request at a time over a valid/ready handshake and performs a byte-enabled word access to an internal RAM after a programmable number of wait states.
- Returns read data or write completion over a second valid/ready response channel.
- Lets the pipelined core be exercised against realistic multi-cycle memory latency instead of a zero-latency array.

---
 rtl/data_memory_responder.sv | 114 +++++++++++
 tb/tb_data_memory_responder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_responder.sv
// data_memory_responder: valid/ready load/store responder for the core's
// MEM-stage data port. One request in flight; the RAM access happens
// WAIT_STATES cycles after acceptance and the result is held until taken.
module data_memory_responder #(
    parameter int          DATA_MEMORY_DEPTH = 128,
    parameter int          WAIT_STATES       = 2,
    parameter logic [31:0] ADDR_BASE         = 32'h1001_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_be_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_error_o
);

    localparam int          CW       = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam int          IW       = (DATA_MEMORY_DEPTH > 1) ? $clog2(DATA_MEMORY_DEPTH) : 1;
    localparam logic [31:0] LIMIT    = 32'(4 * DATA_MEMORY_DEPTH);
    localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_STATES);

    // S_RST is the state the block sits in while reset is held: it behaves
    // like IDLE for the datapath but keeps req_ready_o low, so ready can stay
    // a pure state decode. The first edge after release moves to S_IDLE.
    typedef enum logic [1:0] {S_RST, S_IDLE, S_WAIT, S_RESP} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [31:0]     addr_q, wdata_q;
    logic            write_q;
    logic [3:0]      be_q;
    logic [31:0]     offset;
    logic [IW-1:0]   idx;
    logic            acc_err, access, accept;

    logic [31:0] mem [DATA_MEMORY_DEPTH];

    assign req_ready_o = (state == S_IDLE);
    assign accept      = req_valid_i && req_ready_o;
    assign access      = (state == S_WAIT) && (cnt == '0);

    // Address decode works on the captured request, never on live inputs.
    assign offset  = addr_q - ADDR_BASE;
    assign idx     = offset[IW+1:2];
    assign acc_err = (addr_q[1:0] != 2'b00) || (addr_q < ADDR_BASE) || (offset >= LIMIT);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_RST;
        else        state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            S_RST:   state_nxt = S_IDLE;
            S_IDLE:  if (accept) state_nxt = S_WAIT;
            S_WAIT:  if (cnt == '0) state_nxt = S_RESP;
            S_RESP:  if (rsp_ready_i) state_nxt = S_IDLE;
            default: state_nxt = S_RST;
        endcase
    end

    // Request capture, wait counter and registered response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt         <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            be_q        <= '0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_error_o <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
                write_q <= req_write_i;
                be_q    <= req_be_i;
                cnt     <= CNT_INIT;
            end
            if (state == S_WAIT && cnt != '0)
                cnt <= cnt - 1'b1;
            if (access) begin
                rsp_valid_o <= 1'b1;
                rsp_error_o <= acc_err;
                rsp_rdata_o <= (!acc_err && !write_q) ? mem[idx] : 32'h0;
            end
            if (state == S_RESP && rsp_ready_i) begin
                rsp_valid_o <= 1'b0;
                rsp_error_o <= 1'b0;
                rsp_rdata_o <= '0;
            end
        end
    end

    // RAM byte-enabled write; contents survive reset. The async reset drops
    // the state out of S_WAIT immediately, so an aborted store never lands.
    always_ff @(posedge clk) begin
        if (access && write_q && !acc_err) begin
            for (int k = 0; k < 4; k++)
                if (be_q[k]) mem[idx][8*k +: 8] <= wdata_q[8*k +: 8];
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: two instances (WAIT_STATES=2 and 0)
// checked against an array-based model of the memory map.
module tb_data_memory_responder;

    localparam int          DEPTH = 128;
    localparam int          WS_A  = 2;
    localparam int          WS_B  = 0;
    localparam logic [31:0] BASE  = 32'h1001_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        valid_a = 1'b0, valid_b = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0]  be = '0;
    logic        rsp_ready = 1'b0;
    logic        ready_a, rvalid_a, err_a, ready_b, rvalid_b, err_b;
    logic [31:0] rdata_a, rdata_b;

    int tests = 0;
    int fails = 0;
    bit sel = 1'b0;

    logic [31:0] mem_a [DEPTH];
    logic [31:0] mem_b [DEPTH];

    always #5 clk = ~clk;

    data_memory_responder #(.DATA_MEMORY_DEPTH(DEPTH), .WAIT_STATES(WS_A), .ADDR_BASE(BASE)) dut_a (
        .clk(clk), .reset(reset),
        .req_valid_i(valid_a), .req_ready_o(ready_a), .req_write_i(wr),
        .req_addr_i(addr), .req_wdata_i(wdata), .req_be_i(be),
        .rsp_valid_o(rvalid_a), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rdata_a), .rsp_error_o(err_a));

    data_memory_responder #(.DATA_MEMORY_DEPTH(DEPTH), .WAIT_STATES(WS_B), .ADDR_BASE(BASE)) dut_b (
        .clk(clk), .reset(reset),
        .req_valid_i(valid_b), .req_ready_o(ready_b), .req_write_i(wr),
        .req_addr_i(addr), .req_wdata_i(wdata), .req_be_i(be),
        .rsp_valid_o(rvalid_b), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rdata_b), .rsp_error_o(err_b));

    wire        ready_s  = sel ? ready_b  : ready_a;
    wire        rvalid_s = sel ? rvalid_b : rvalid_a;
    wire [31:0] rdata_s  = sel ? rdata_b  : rdata_a;
    wire        err_s    = sel ? err_b    : err_a;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory-map model: flat word array, fault if misaligned or outside
    // [BASE, BASE + 4*DEPTH).
    task automatic model_acc(input bit s, input bit w, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] b, output logic [31:0] er, output logic ee);
        longint la = a;
        int i;
        logic [31:0] cur;
        ee = (la % 4 != 0) || (la < longint'(BASE)) || (la >= longint'(BASE) + 4 * DEPTH);
        er = '0;
        if (!ee) begin
            i = int'((la - longint'(BASE)) / 4);
            cur = s ? mem_b[i] : mem_a[i];
            if (w) begin
                for (int k = 0; k < 4; k++)
                    if (b[k]) cur[8*k +: 8] = d[8*k +: 8];
                if (s) mem_b[i] = cur; else mem_a[i] = cur;
            end else begin
                er = cur;
            end
        end
    endtask

    // One full transaction with immediate response acceptance.
    task automatic xact(input bit s, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, input string tag, output logic [31:0] ro);
        int n = 0;
        int lat = 0;
        logic [31:0] er;
        logic ee, eo;
        sel = s;
        while (!ready_s && n < 20) begin @(posedge clk); #1; n++; end
        if (!ready_s) chk({tag, "_ready_timeout"}, 32'(ready_s), 32'd1);
        wr = w; addr = a; wdata = d; be = b;
        if (s) valid_b = 1'b1; else valid_a = 1'b1;
        @(posedge clk); #1;
        valid_a = 1'b0; valid_b = 1'b0;
        while (lat < 20) begin
            @(posedge clk); #1; lat++;
            if (rvalid_s) break;
        end
        model_acc(s, w, a, d, b, er, ee);
        chk({tag, "_lat"}, 32'(lat), 32'((s ? WS_B : WS_A) + 1));
        ro = rdata_s; eo = err_s;
        chk({tag, "_rdata"}, ro, er);
        chk({tag, "_err"}, 32'(eo), 32'(ee));
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({tag, "_rsp_drop"}, 32'(rvalid_s), 32'd0);
        chk({tag, "_idle_ready"}, 32'(ready_s), 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r, ra, e0, d;
        int sel_r;
        bit s, w;

        // Reset held with a request present.
        reset = 1'b0; valid_a = 1'b1; valid_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready_a", 32'(ready_a), 32'd0);
        chk("rst_ready_b", 32'(ready_b), 32'd0);
        chk("rst_rvalid_a", 32'(rvalid_a), 32'd0);
        chk("rst_rdata_a", rdata_a, 32'd0);
        chk("rst_err_a", 32'(err_a), 32'd0);
        @(negedge clk);
        reset = 1'b1; valid_a = 1'b0; valid_b = 1'b0;
        @(posedge clk); #1;
        chk("rel_ready_a", 32'(ready_a), 32'd1);
        chk("rel_ready_b", 32'(ready_b), 32'd1);

        // Give every word a known value so the model is fully defined.
        for (int i = 0; i < DEPTH; i++) begin
            xact(1'b0, 1'b1, BASE + 32'(4 * i), 32'h0, 4'hF, "fill_a", r);
            xact(1'b1, 1'b1, BASE + 32'(4 * i), 32'h0, 4'hF, "fill_b", r);
        end

        // Directed store/load and byte enables.
        xact(1'b0, 1'b1, 32'h1001_0010, 32'hDEAD_BEEF, 4'hF, "st_full", r);
        chk("st_full_zero", r, 32'h0);
        xact(1'b0, 1'b0, 32'h1001_0010, 32'h0, 4'h0, "ld_full", r);
        chk("ld_full_val", r, 32'hDEAD_BEEF);
        xact(1'b0, 1'b1, 32'h1001_0010, 32'h1122_3344, 4'b0101, "st_be", r);
        xact(1'b0, 1'b0, 32'h1001_0010, 32'h0, 4'hF, "ld_be", r);
        chk("ld_be_val", r, 32'hDE22_BE44);
        xact(1'b0, 1'b1, 32'h1001_0010, 32'hFFFF_FFFF, 4'b0000, "st_nobe", r);
        xact(1'b0, 1'b0, 32'h1001_0010, 32'h0, 4'hF, "ld_nobe", r);
        chk("ld_nobe_val", r, 32'hDE22_BE44);
        xact(1'b0, 1'b0, 32'h1001_01FC, 32'h0, 4'hF, "ld_last", r);

        // Faults.
        xact(1'b0, 1'b0, 32'h1001_0002, 32'h0, 4'hF, "ld_misal", r);
        xact(1'b0, 1'b0, 32'h1001_0200, 32'h0, 4'hF, "ld_over", r);
        xact(1'b0, 1'b1, 32'h1000_FFFC, 32'h5555_AAAA, 4'hF, "st_below", r);
        xact(1'b0, 1'b0, 32'h1001_0000, 32'h0, 4'hF, "ld_word0", r);
        chk("ld_word0_val", r, 32'h0);

        // Backpressure: response held while a new request is offered.
        sel = 1'b0; wr = 1'b0; addr = 32'h1001_0010; be = 4'hF; valid_a = 1'b1;
        @(posedge clk); #1;
        valid_a = 1'b0;
        for (int i = 0; i < 10 && !rvalid_a; i++) begin @(posedge clk); #1; end
        chk("bp_valid", 32'(rvalid_a), 32'd1);
        ra = rdata_a;
        chk("bp_rdata", ra, mem_a[4]);
        wr = 1'b1; addr = 32'h1001_0040; wdata = 32'h1234_5678; valid_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", 32'(rvalid_a), 32'd1);
            chk("bp_hold_rdata", rdata_a, ra);
            chk("bp_hold_err", 32'(err_a), 32'd0);
            chk("bp_hold_ready", 32'(ready_a), 32'd0);
        end
        valid_a = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("bp_rel_valid", 32'(rvalid_a), 32'd0);
        chk("bp_rel_rdata", rdata_a, 32'd0);
        chk("bp_rel_ready", 32'(ready_a), 32'd1);
        @(posedge clk); #1;
        chk("bp_no_accept", 32'(rvalid_a), 32'd0);
        chk("bp_no_accept_rdy", 32'(ready_a), 32'd1);
        xact(1'b0, 1'b0, 32'h1001_0040, 32'h0, 4'hF, "bp_ld_untouched", r);

        // Reset during WAIT aborts a store.
        sel = 1'b0; wr = 1'b1; addr = 32'h1001_0020; wdata = 32'hCAFE_F00D; be = 4'hF; valid_a = 1'b1;
        @(posedge clk); #1;
        valid_a = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(ready_a), 32'd0);
        chk("mid_rst_valid", 32'(rvalid_a), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_rel_ready", 32'(ready_a), 32'd1);
        xact(1'b0, 1'b0, 32'h1001_0020, 32'h0, 4'hF, "mid_ld", r);
        chk("mid_ld_val", r, 32'h0);

        // Zero wait states.
        xact(1'b1, 1'b1, 32'h1001_0010, 32'hDEAD_BEEF, 4'hF, "ws0_st", r);
        xact(1'b1, 1'b0, 32'h1001_0010, 32'h0, 4'hF, "ws0_ld", r);
        chk("ws0_ld_val", r, 32'hDEAD_BEEF);

        // Randomized traffic on both instances.
        for (int i = 0; i < 120; i++) begin
            s = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            sel_r = int'($urandom_range(0, 9));
            case (sel_r)
                0: a_misal: begin
                    d = BASE + 32'($urandom_range(0, 511));
                    addr = (d[1:0] == 2'b00) ? d + 32'd1 : d;
                end
                1: addr = BASE + 32'd512 + 32'(4 * $urandom_range(0, 16));
                2: addr = BASE - 32'(4 * $urandom_range(1, 8));
                default: addr = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
            endcase
            e0 = $urandom;
            xact(s, w, addr, e0, 4'($urandom_range(0, 15)), "rand", r);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
